// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (0..MOD-1) with up/down stepping, synchronous
// clear, range-checked preset load and a same-cycle carry/borrow for cascading.
module bcd_mod_counter #(
  parameter int MOD  = 60,
  parameter int QH_W = 3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic            i_clr,
  input  logic            i_up,
  input  logic            i_ld,
  input  logic [QH_W-1:0] i_dh,
  input  logic [3:0]      i_dl,
  output logic [QH_W-1:0] o_qh,
  output logic [3:0]      o_ql,
  output logic            o_ca,
  output logic            o_lderr
);

  // Terminal count MOD-1 split into its BCD digits.
  localparam logic [QH_W-1:0] LP_MAXH = QH_W'((MOD - 1) / 10);
  localparam logic [3:0]      LP_MAXL = 4'((MOD - 1) % 10);

  logic [QH_W-1:0] r_qh;
  logic [3:0]      r_ql;
  logic            r_lderr;

  logic            w_at_max;
  logic            w_at_zero;
  logic            w_step;
  logic [31:0]     w_dval;
  logic            w_ld_ok;
  logic [QH_W-1:0] w_step_qh;
  logic [3:0]      w_step_ql;

  assign w_at_max  = (r_qh == LP_MAXH) && (r_ql == LP_MAXL);
  assign w_at_zero = (r_qh == '0) && (r_ql == 4'd0);

  // A count step only happens when neither clear nor load claims the edge.
  assign w_step = i_en & ~i_clr & ~i_ld;

  // Preset is accepted only if it is valid BCD and inside the modulus.
  assign w_dval  = 32'(i_dh) * 32'd10 + 32'(i_dl);
  assign w_ld_ok = (i_dl <= 4'd9) && (w_dval <= 32'(MOD - 1));

  // Carry/borrow is combinational so the next stage steps on the same edge.
  assign o_ca = i_rst_n & w_step & ((i_up & w_at_max) | (~i_up & w_at_zero));

  // Next value for one up or down step, wrapping at 0 and MOD-1.
  always_comb begin
    w_step_qh = r_qh;
    w_step_ql = r_ql;
    if (i_up) begin
      if (w_at_max) begin
        w_step_qh = '0;
        w_step_ql = 4'd0;
      end else if (r_ql == 4'd9) begin
        w_step_ql = 4'd0;
        w_step_qh = r_qh + 1'b1;
      end else begin
        w_step_ql = r_ql + 4'd1;
      end
    end else begin
      if (w_at_zero) begin
        w_step_qh = LP_MAXH;
        w_step_ql = LP_MAXL;
      end else if (r_ql == 4'd0) begin
        w_step_ql = 4'd9;
        w_step_qh = r_qh - 1'b1;
      end else begin
        w_step_ql = r_ql - 4'd1;
      end
    end
  end

  // Value and load-error register: clear beats load beats count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_qh    <= '0;
      r_ql    <= 4'd0;
      r_lderr <= 1'b0;
    end else if (i_clr) begin
      r_qh    <= '0;
      r_ql    <= 4'd0;
      r_lderr <= 1'b0;
    end else if (i_ld) begin
      if (w_ld_ok) begin
        r_qh    <= i_dh;
        r_ql    <= i_dl;
        r_lderr <= 1'b0;
      end else begin
        r_lderr <= 1'b1;
      end
    end else begin
      r_lderr <= 1'b0;
      if (i_en) begin
        r_qh <= w_step_qh;
        r_ql <= w_step_ql;
      end
    end
  end

  assign o_qh    = r_qh;
  assign o_ql    = r_ql;
  assign o_lderr = r_lderr;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: a MOD=60 instance and a MOD=24 instance.
module tb_bcd_mod_counter;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       a_en, a_clr, a_up, a_ld;
  logic [2:0] a_dh;
  logic [3:0] a_dl;
  logic [2:0] a_qh;
  logic [3:0] a_ql;
  logic       a_ca, a_lderr;

  logic       b_en, b_clr, b_up, b_ld;
  logic [1:0] b_dh;
  logic [3:0] b_dl;
  logic [1:0] b_qh;
  logic [3:0] b_ql;
  logic       b_ca, b_lderr;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  bcd_mod_counter #(.MOD(60), .QH_W(3)) u60 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(a_en), .i_clr(a_clr), .i_up(a_up),
    .i_ld(a_ld), .i_dh(a_dh), .i_dl(a_dl), .o_qh(a_qh), .o_ql(a_ql),
    .o_ca(a_ca), .o_lderr(a_lderr)
  );

  bcd_mod_counter #(.MOD(24), .QH_W(2)) u24 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(b_en), .i_clr(b_clr), .i_up(b_up),
    .i_ld(b_ld), .i_dh(b_dh), .i_dl(b_dl), .o_qh(b_qh), .o_ql(b_ql),
    .o_ca(b_ca), .o_lderr(b_lderr)
  );

  // Advance one edge; outputs are observed 1ns after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load60(input logic [2:0] dh, input logic [3:0] dl);
    a_ld = 1'b1; a_dh = dh; a_dl = dl;
    tick();
    a_ld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_en = 0; a_clr = 0; a_up = 1; a_ld = 0; a_dh = 0; a_dl = 0;
    b_en = 0; b_clr = 0; b_up = 1; b_ld = 0; b_dh = 0; b_dl = 0;
    tick(2);
    total_cnt++;
    if ({a_qh, a_ql, a_ca, a_lderr} !== {3'd0, 4'd0, 1'b0, 1'b0})
      $display("FAIL reset60 got %0d:%0d ca=%0b le=%0b exp 0:0 ca=0 le=0", a_qh, a_ql, a_ca, a_lderr);
    else pass_cnt++;
    total_cnt++;
    if ({b_qh, b_ql, b_ca, b_lderr} !== {2'd0, 4'd0, 1'b0, 1'b0})
      $display("FAIL reset24 got %0d:%0d ca=%0b le=%0b exp 0:0 ca=0 le=0", b_qh, b_ql, b_ca, b_lderr);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_count_up();
    a_up = 1; a_en = 1;
    tick(10);
    total_cnt++;
    if ({a_qh, a_ql} !== {3'd1, 4'd0})
      $display("FAIL up_tens got %0d:%0d exp 1:0", a_qh, a_ql);
    else pass_cnt++;
    tick(49);
    total_cnt++;
    if ({a_qh, a_ql, a_ca} !== {3'd5, 4'd9, 1'b1})
      $display("FAIL up_59 got %0d:%0d ca=%0b exp 5:9 ca=1", a_qh, a_ql, a_ca);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({a_qh, a_ql, a_ca} !== {3'd0, 4'd0, 1'b0})
      $display("FAIL up_wrap got %0d:%0d ca=%0b exp 0:0 ca=0", a_qh, a_ql, a_ca);
    else pass_cnt++;
    a_en = 0;
  endtask

  task automatic test_count_down();
    a_up = 0; a_en = 1;
    #1;
    total_cnt++;
    if (a_ca !== 1'b1)
      $display("FAIL down_borrow got ca=%0b exp ca=1", a_ca);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({a_qh, a_ql, a_ca} !== {3'd5, 4'd9, 1'b0})
      $display("FAIL down_wrap got %0d:%0d ca=%0b exp 5:9 ca=0", a_qh, a_ql, a_ca);
    else pass_cnt++;
    a_en = 0;
    load60(3'd1, 4'd0);
    a_en = 1;
    tick();
    total_cnt++;
    if ({a_qh, a_ql} !== {3'd0, 4'd9})
      $display("FAIL down_tens got %0d:%0d exp 0:9", a_qh, a_ql);
    else pass_cnt++;
    a_up = 1;
    tick();
    total_cnt++;
    if ({a_qh, a_ql} !== {3'd1, 4'd0})
      $display("FAIL dir_change got %0d:%0d exp 1:0", a_qh, a_ql);
    else pass_cnt++;
    a_en = 0;
  endtask

  task automatic test_mod24();
    b_up = 1; b_en = 1;
    tick(23);
    total_cnt++;
    if ({b_qh, b_ql, b_ca} !== {2'd2, 4'd3, 1'b1})
      $display("FAIL m24_23 got %0d:%0d ca=%0b exp 2:3 ca=1", b_qh, b_ql, b_ca);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({b_qh, b_ql} !== {2'd0, 4'd0})
      $display("FAIL m24_wrap got %0d:%0d exp 0:0", b_qh, b_ql);
    else pass_cnt++;
    b_en = 0;
    b_ld = 1; b_dh = 2'd2; b_dl = 4'd4;
    tick();
    b_ld = 0;
    total_cnt++;
    if ({b_qh, b_ql, b_lderr} !== {2'd0, 4'd0, 1'b1})
      $display("FAIL m24_ld24 got %0d:%0d le=%0b exp 0:0 le=1", b_qh, b_ql, b_lderr);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (b_lderr !== 1'b0)
      $display("FAIL m24_lderr_pulse got le=%0b exp le=0", b_lderr);
    else pass_cnt++;
  endtask

  task automatic test_load();
    load60(3'd4, 4'd7);
    total_cnt++;
    if ({a_qh, a_ql, a_lderr} !== {3'd4, 4'd7, 1'b0})
      $display("FAIL ld47 got %0d:%0d le=%0b exp 4:7 le=0", a_qh, a_ql, a_lderr);
    else pass_cnt++;
    load60(3'd3, 4'hA);
    total_cnt++;
    if ({a_qh, a_ql, a_lderr} !== {3'd4, 4'd7, 1'b1})
      $display("FAIL ld3A got %0d:%0d le=%0b exp 4:7 le=1", a_qh, a_ql, a_lderr);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (a_lderr !== 1'b0)
      $display("FAIL ld3A_pulse got le=%0b exp le=0", a_lderr);
    else pass_cnt++;
    load60(3'd6, 4'd0);
    total_cnt++;
    if ({a_qh, a_ql, a_lderr} !== {3'd4, 4'd7, 1'b1})
      $display("FAIL ld60 got %0d:%0d le=%0b exp 4:7 le=1", a_qh, a_ql, a_lderr);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (a_lderr !== 1'b0)
      $display("FAIL ld60_pulse got le=%0b exp le=0", a_lderr);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    load60(3'd5, 4'd9);
    a_up = 1; a_en = 1; a_clr = 1; a_ld = 1; a_dh = 3'd1; a_dl = 4'd2;
    #1;
    total_cnt++;
    if (a_ca !== 1'b0)
      $display("FAIL prio_ca got ca=%0b exp ca=0", a_ca);
    else pass_cnt++;
    tick();
    a_clr = 0;
    total_cnt++;
    if ({a_qh, a_ql, a_lderr} !== {3'd0, 4'd0, 1'b0})
      $display("FAIL prio_clr got %0d:%0d le=%0b exp 0:0 le=0", a_qh, a_ql, a_lderr);
    else pass_cnt++;
    tick();
    a_ld = 0; a_en = 0;
    total_cnt++;
    if ({a_qh, a_ql} !== {3'd1, 4'd2})
      $display("FAIL prio_ld_en got %0d:%0d exp 1:2", a_qh, a_ql);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({a_qh, a_ql} !== {3'd1, 4'd2})
      $display("FAIL idle_hold got %0d:%0d exp 1:2", a_qh, a_ql);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    load60(3'd3, 4'd6);
    a_up = 1; a_en = 1;
    tick();
    total_cnt++;
    if ({a_qh, a_ql} !== {3'd3, 4'd7})
      $display("FAIL pre_rst got %0d:%0d exp 3:7", a_qh, a_ql);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({a_qh, a_ql, a_ca} !== {3'd0, 4'd0, 1'b0})
      $display("FAIL async_rst got %0d:%0d ca=%0b exp 0:0 ca=0", a_qh, a_ql, a_ca);
    else pass_cnt++;
    #1;
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if ({a_qh, a_ql} !== {3'd0, 4'd1})
      $display("FAIL post_rst got %0d:%0d exp 0:1", a_qh, a_ql);
    else pass_cnt++;
    a_en = 0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_mod24();
    test_load();
    test_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
